// File: rtl/polar_hd_decoder_if.sv
// Codeword-in / result-out handshake bundle for the polar hard-decision decoder.
interface polar_hd_if;
   logic        in_valid;
   logic        in_ready;
   logic [63:0] in_cw;
   logic        out_valid;
   logic        out_ready;
   logic [23:0] out_data;
   logic [1:0]  out_flips;
   logic        out_fail;

   modport master (
      output in_valid, in_cw, out_ready,
      input  in_ready, out_valid, out_data, out_flips, out_fail
   );

   modport slave (
      input  in_valid, in_cw, out_ready,
      output in_ready, out_valid, out_data, out_flips, out_fail
   );
endinterface

// File: rtl/polar_hd_decoder.sv
// Bounded-distance hard-decision decoder for the (64,40) CRC-aided polar code.
// Tries error patterns of weight 0, 1, 2 in fixed order, one candidate per clock.
package polar_hd_pkg;
   // Info set = rows of weight >= 8 (popcount >= 3) minus rows 7 and 11, so dmin >= 8.
   localparam int INFO_POS [40] = '{
      13, 14, 15, 19, 21, 22, 23, 25, 26, 27, 28, 29, 30, 31, 35, 37, 38, 39, 41, 42,
      43, 44, 45, 46, 47, 49, 50, 51, 52, 53, 54, 55, 56, 57, 58, 59, 60, 61, 62, 63};
   localparam int FROZEN_POS [24] = '{
      0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 16, 17, 18, 20, 24, 32, 33, 34, 36, 40, 48};

   function automatic logic [63:0] polar_transform64(input logic [63:0] x);
      logic [63:0] v;
      v = x;
      for (int l = 0; l < 6; l++) begin
         for (int i = 0; i < 64; i++) begin
            if ((i & (1 << l)) == 0) v[i] = v[i] ^ v[i + (1 << l)];
         end
      end
      return v;
   endfunction

   function automatic logic [15:0] crc16_ccitt24(input logic [23:0] d);
      logic [15:0] crc;
      logic        fb;
      crc = 16'h0000;
      for (int b = 23; b >= 0; b--) begin
         fb  = crc[15] ^ d[b];
         crc = {crc[14:0], 1'b0};
         if (fb) crc = crc ^ 16'h1021;
      end
      return crc;
   endfunction

   function automatic logic [23:0] info_data(input logic [63:0] u);
      logic [23:0] d;
      d = '0;
      for (int k = 0; k < 24; k++) d[23-k] = u[INFO_POS[k]];
      return d;
   endfunction

   function automatic logic [15:0] info_crc(input logic [63:0] u);
      logic [15:0] c;
      c = '0;
      for (int k = 0; k < 16; k++) c[15-k] = u[INFO_POS[24+k]];
      return c;
   endfunction

   function automatic logic frozen_clear(input logic [63:0] u);
      logic ok;
      ok = 1'b1;
      for (int k = 0; k < 24; k++) if (u[FROZEN_POS[k]]) ok = 1'b0;
      return ok;
   endfunction
endpackage

// state  | meaning
// IDLE   | waiting for a codeword (in_ready high once out of reset)
// SEARCH | evaluating candidate r_c against the stored codeword
// DONE   | result held on the outputs until the consumer takes it
module polar_hd_decoder
   import polar_hd_pkg::*;
#(
   parameter int MAX_FLIPS = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   polar_hd_if.slave bus
);

   if (MAX_FLIPS < 0 || MAX_FLIPS > 2) begin : g_bad_max_flips
      $error("polar_hd_decoder: MAX_FLIPS must be 0, 1 or 2");
   end

   localparam logic [11:0] LAST_C = (MAX_FLIPS == 0) ? 12'd0 :
                                    (MAX_FLIPS == 1) ? 12'd64 : 12'd2080;

   typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_DONE} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_alive;
   logic [63:0] r_cw;
   logic [11:0] r_c;
   logic [1:0]  r_wt;
   logic [5:0]  r_i;
   logic [5:0]  r_j;
   logic [23:0] r_data;
   logic [23:0] r_data0;
   logic [1:0]  r_flips;
   logic        r_fail;

   logic [63:0] w_err;
   logic [63:0] w_u;
   logic [23:0] w_data_hat;
   logic        w_pass;
   logic        w_last;
   logic        w_in_ready;
   logic        w_accept;

   // r_wt selects the pattern family; r_i/r_j walk the flip positions in order.
   always_comb begin
      w_err = '0;
      if (r_wt != 2'd0) w_err[r_i] = 1'b1;
      if (r_wt == 2'd2) w_err[r_j] = 1'b1;
   end

   assign w_u        = polar_transform64(r_cw ^ w_err);
   assign w_data_hat = info_data(w_u);
   assign w_pass     = frozen_clear(w_u) && (crc16_ccitt24(w_data_hat) == info_crc(w_u));
   assign w_last     = (r_c == LAST_C);

   assign w_in_ready    = r_alive && (r_state == S_IDLE);
   assign w_accept      = bus.in_valid && w_in_ready;
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == S_DONE);
   assign bus.out_data  = r_data;
   assign bus.out_flips = r_flips;
   assign bus.out_fail  = r_fail;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_accept) w_state_nxt = S_SEARCH;
         S_SEARCH: if (w_pass || w_last) w_state_nxt = S_DONE;
         S_DONE:   if (bus.out_ready) w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_alive <= 1'b0;
         r_cw    <= '0;
         r_c     <= '0;
         r_wt    <= '0;
         r_i     <= '0;
         r_j     <= '0;
         r_data  <= '0;
         r_data0 <= '0;
         r_flips <= '0;
         r_fail  <= 1'b0;
      end else begin
         r_alive <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_cw <= bus.in_cw;
                  r_c  <= '0;
                  r_wt <= '0;
                  r_i  <= '0;
                  r_j  <= '0;
               end
            end
            S_SEARCH: begin
               if (r_c == 12'd0) r_data0 <= w_data_hat;
               if (w_pass) begin
                  r_data  <= w_data_hat;
                  r_flips <= r_wt;
                  r_fail  <= 1'b0;
               end else if (w_last) begin
                  // Failure reports the uncorrected data (candidate 0).
                  r_data  <= (r_c == 12'd0) ? w_data_hat : r_data0;
                  r_flips <= 2'd0;
                  r_fail  <= 1'b1;
               end else begin
                  r_c <= r_c + 12'd1;
                  case (r_wt)
                     2'd0: begin
                        r_wt <= 2'd1;
                        r_i  <= 6'd0;
                     end
                     2'd1: begin
                        if (r_i == 6'd63) begin
                           r_wt <= 2'd2;
                           r_i  <= 6'd0;
                           r_j  <= 6'd1;
                        end else begin
                           r_i <= r_i + 6'd1;
                        end
                     end
                     default: begin
                        if (r_j == 6'd63) begin
                           r_i <= r_i + 6'd1;
                           r_j <= r_i + 6'd2;
                        end else begin
                           r_j <= r_j + 6'd1;
                        end
                     end
                  endcase
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/polar_hd_decoder.md
Name: polar_hd_decoder

Overview:
- Hard-decision, bounded-distance decoder for the N=64, K=40 CRC-aided polar code (24 data bits + 16-bit CRC-16-CCITT, 24 frozen bits).
- Sits at the receive end of the link, after the channel and opposite the encoder. It accepts one 64-bit received codeword and searches error patterns of weight 0, 1, then 2, one candidate per cycle.
- It returns the first candidate whose u_hat has all frozen bits zero and a matching CRC, together with the 24-bit data and the number of flips applied.

Parameters:
- MAX_FLIPS, 2, highest error-pattern weight searched; legal values 0, 1, 2.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  received codeword offered.
- in_ready  out  1  decoder can accept a codeword.
- in_cw  in  64  received codeword; bit i is codeword position i.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  24  decoded data; out_data[23-k] = u_hat[INFO_POS[k]].
- out_flips  out  2  weight of the applied error pattern (0..2).
- out_fail  out  1  no candidate passed within MAX_FLIPS.

Behaviour:
- Reset is asynchronous, active-low, one clock. It applies with any flip/state.
  - Values during reset: in_ready=0, out_valid=0, out_data=0, out_flips=0, out_fail=0, FSM=IDLE, counters=0.
  - in_ready=1 from the first clk edge after rst_n deasserts.
  - Reset during SEARCH or DONE aborts the job; no result is ever emitted for it.
- FSM states: IDLE, SEARCH, DONE.
  - IDLE: in_ready=1. On in_valid&in_ready at edge T, register in_cw and go to SEARCH with candidate index c=0.
  - SEARCH: in_ready=0. Each cycle evaluates candidate c.
    - On pass, or on the last candidate, register the result and go to DONE; out_valid rises at edge T+1+c.
    - Otherwise increment c.
  - DONE: out_valid=1. Outputs hold stable until out_valid&out_ready; that edge goes to IDLE with out_valid=0.
  - No new input is accepted in the DONE-to-IDLE cycle: in_ready=0 in DONE.
- Candidate order, fixed and deterministic:
  - c=0: no flip.
  - c=1..64: flip bit i=c-1 (only if MAX_FLIPS>=1).
  - c=65..2080: flip pairs (i,j), i<j, lexicographic — (0,1),(0,2),...,(0,63),(1,2),...,(62,63) (only if MAX_FLIPS=2).
  - Last index: 0, 64 or 2080 for MAX_FLIPS 0, 1, 2.
- Candidate check is combinational within one cycle:
  - cand = cw ^ e, where e is the error pattern for index c.
  - u_hat = polar_transform64(cand); the transform is self-inverse, no bit reversal.
  - Pass when u_hat[FROZEN_POS[*]] are all 0 AND crc16_ccitt24(data_hat) == crc_hat, where crc_hat[15-k] = u_hat[INFO_POS[24+k]].
  - Use the package functions/tables; do not re-derive them.
- First pass wins; later candidates are never evaluated.
  - out_flips = pattern weight, out_fail = 0.
- Failure (no candidate passes):
  - out_fail = 1, out_flips = 0.
  - out_data = data extracted from the uncorrected u_hat (candidate 0).
- Latency:
  - Clean codeword: 1 cycle (out_valid at T+1).
  - Worst case with MAX_FLIPS=2: 2081 cycles.
- Throughput: one codeword in flight. Counters are sized for 2080 (12 bits); no wrap-around is possible.
- Illegal MAX_FLIPS is an elaboration-time error.

Test Plan:
1. in_cw=0 accepted at T → out_valid at T+1, out_data=0, out_flips=0, out_fail=0; in_ready low until handshake completes.
2. Encode data 24'hA5C3E1 (build_u + polar_transform64), flip bit 5 → out_valid at T+7, out_data=24'hA5C3E1, out_flips=1, out_fail=0.
3. in_cw = 0 with bits 0 and 1 flipped (64'h3) → out_valid at T+66, out_data=0, out_flips=2.
4. Encoded codeword with bits 3, 17, 40 flipped, MAX_FLIPS=2 → no candidate within radius 2 (dmin>=8), so out_valid at T+2081, out_fail=1, out_flips=0.
5. Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0, a second in_valid is not accepted; release → IDLE next edge, second job decodes correctly.
6. Assert rst_n=0 at T+30 of a 3-flip job → all outputs 0 immediately; after release, a clean codeword returns in 1 cycle and no stale result appears.
